// File: rtl/combination_lock_param.sv
// -----------------------------------------------------------------------------
// combination_lock_param
//   N-digit dial combination lock. A digit is sampled on each direction
//   reversal of the dial: digit k is expected while turning Left for even k
//   and Right for odd k, and an attempt starts with a Right turn in IDLE.
//   When all NUM_DIGITS digits match COMBO the lock opens until Center.
//
//   Optional feature macro: LOCKOUT_EN
//     defined   -> MAX_FAILS mismatches enter LOCKOUT for LOCKOUT_CYCLES clocks
//     undefined -> mismatches always return to IDLE, LockedOut tied low
//
// Ports
//   Clk        in   system clock, rising edge
//   South      in   synchronous active-high reset
//   Right      in   dial turning right (level)
//   Left       in   dial turning left (level)
//   Count      in   dial position, COUNT_W bits
//   Center     in   relock in OPEN / abort in ENTER
//   state      out  0 IDLE, 1 ENTER, 2 OPEN, 3 LOCKOUT
//   digit_idx  out  index of the digit currently awaited
//   Locked     out  high unless state is OPEN
//   Fail       out  one-cycle registered pulse per digit mismatch
//   LockedOut  out  high while state is LOCKOUT
// -----------------------------------------------------------------------------
module combination_lock_param #(
  parameter int                            NUM_DIGITS     = 3,
  parameter int                            COUNT_W        = 5,
  parameter int                            IDX_W          = 2,
  parameter logic [NUM_DIGITS*COUNT_W-1:0] COMBO          = {5'd17, 5'd7, 5'd13},
  parameter int                            MAX_FAILS      = 3,
  parameter int                            LOCKOUT_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               South,
  input  logic               Right,
  input  logic               Left,
  input  logic [COUNT_W-1:0] Count,
  input  logic               Center,
  output logic [2:0]         state,
  output logic [IDX_W-1:0]   digit_idx,
  output logic               Locked,
  output logic               Fail,
  output logic               LockedOut
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               fail_q;

  logic               right_s;
  logic               left_s;
  logic               dir_ok_s;
  logic               match_s;
  logic [COUNT_W-1:0] digit_s;

  // Combination digits unpacked into a table covering every index value,
  // so a lookup with idx_q can never fall outside the array.
  logic [COUNT_W-1:0] combo_a [2**IDX_W];

  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_combo
    if (g < NUM_DIGITS) begin : g_used
      assign combo_a[g] = COMBO[g*COUNT_W +: COUNT_W];
    end else begin : g_unused
      assign combo_a[g] = '0;
    end
  end

  // Direction decode and digit compare; both levels high means no direction.
  always_comb begin
    right_s  = Right & ~Left;
    left_s   = Left & ~Right;
    // Even digits are dialled turning Left, odd digits turning Right.
    dir_ok_s = idx_q[0] ? right_s : left_s;
    digit_s  = combo_a[idx_q];
    match_s  = (Count == digit_s);
  end

`ifdef LOCKOUT_EN
  localparam int                FCNT_W     = $clog2(MAX_FAILS + 1);
  localparam int                TMR_W      = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FAILS_MAX  = FCNT_W'(MAX_FAILS);
  localparam logic [FCNT_W-1:0] FAILS_LAST = FCNT_W'(MAX_FAILS - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);

  logic [FCNT_W-1:0] fail_cnt_q;
  logic [FCNT_W-1:0] fail_cnt_d;
  logic [TMR_W-1:0]  timer_q;
  logic              lock_now_s;

  // Saturating fail count if the current sample turns out to be a mismatch.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    lock_now_s = 1'b0;
    if (fail_cnt_q >= FAILS_LAST) begin
      fail_cnt_d = FAILS_MAX;
      lock_now_s = 1'b1;
    end else begin
      fail_cnt_d = fail_cnt_q + FCNT_W'(1);
      lock_now_s = 1'b0;
    end
  end
`endif

  // Lock FSM with registered index and Fail pulse.
  always_ff @(posedge Clk) begin
    if (South) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      fail_q     <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt_q <= '0;
      timer_q    <= '0;
`endif
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (right_s) begin
            state_q <= ST_ENTER;
            idx_q   <= '0;
          end
        end
        ST_ENTER: begin
          // Center aborts even when a valid direction is present.
          if (Center) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end else if (dir_ok_s) begin
            if (match_s) begin
              if (idx_q == LAST_IDX) begin
                state_q    <= ST_OPEN;
                idx_q      <= '0;
`ifdef LOCKOUT_EN
                fail_cnt_q <= '0;
`endif
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              fail_q <= 1'b1;
              idx_q  <= '0;
`ifdef LOCKOUT_EN
              fail_cnt_q <= fail_cnt_d;
              if (lock_now_s) begin
                state_q <= ST_LOCKOUT;
                timer_q <= TMR_LOAD;
              end else begin
                state_q <= ST_IDLE;
              end
`else
              state_q <= ST_IDLE;
`endif
            end
          end
        end
        ST_OPEN: begin
          if (Center) begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
`ifdef LOCKOUT_EN
          // Timer was loaded with LOCKOUT_CYCLES-1, so the exit edge is the
          // LOCKOUT_CYCLES-th cycle spent here.
          if (timer_q == '0) begin
            state_q    <= ST_IDLE;
            fail_cnt_q <= '0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
`else
          state_q <= ST_IDLE;
          idx_q   <= '0;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign digit_idx = idx_q;
  assign Fail      = fail_q;
  assign Locked    = (state_q != ST_OPEN);
`ifdef LOCKOUT_EN
  assign LockedOut = (state_q == ST_LOCKOUT);
`else
  assign LockedOut = 1'b0;
`endif

endmodule

// File: tb/tb_combination_lock_param.sv
// -----------------------------------------------------------------------------
// tb_combination_lock_param
//   Drives a default 3-digit lock and a 4-digit lock from shared inputs and
//   compares both against a behavioural model every cycle, plus directed
//   checks of the documented scenarios. Honours LOCKOUT_EN like the design.
// -----------------------------------------------------------------------------
module tb_combination_lock_param;

  localparam logic [19:0] COMBO3 = {5'd0, 5'd17, 5'd7, 5'd13};
  localparam logic [19:0] COMBO4 = {5'd3, 5'd31, 5'd0, 5'd9};
`ifdef LOCKOUT_EN
  localparam int MAXF     = 3;
  localparam int LOCK_CYC = 16;
`endif

  typedef struct packed {
    int st;
    int idx;
    int fails;
    int tmr;
    bit fail;
  } mdl_t;

  logic       Clk;
  logic       South;
  logic       Right;
  logic       Left;
  logic [4:0] Count;
  logic       Center;

  logic [2:0] state3, state4;
  logic [1:0] idx3, idx4;
  logic       locked3, locked4, fail3, fail4, lo3, lo4;

  int   checks;
  int   errors;
  mdl_t m3, m4;

  combination_lock_param dut3 (
    .Clk(Clk), .South(South), .Right(Right), .Left(Left), .Count(Count),
    .Center(Center), .state(state3), .digit_idx(idx3), .Locked(locked3),
    .Fail(fail3), .LockedOut(lo3)
  );

  combination_lock_param #(
    .NUM_DIGITS(4),
    .COMBO({5'd3, 5'd31, 5'd0, 5'd9})
  ) dut4 (
    .Clk(Clk), .South(South), .Right(Right), .Left(Left), .Count(Count),
    .Center(Center), .state(state4), .digit_idx(idx4), .Locked(locked4),
    .Fail(fail4), .LockedOut(lo4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int digit_of(input logic [19:0] combo, input int k);
    logic [19:0] t;
    t = combo >> (k * 5);
    return int'(t[4:0]);
  endfunction

  // Behavioural model of one lock: next model state from current inputs.
  function automatic mdl_t model_next(input mdl_t m, input bit s, input bit r,
                                      input bit l, input int cnt, input bit c,
                                      input int nd, input logic [19:0] combo);
    mdl_t n;
    bit   want;
    n      = m;
    n.fail = 1'b0;
    if (s) begin
      n.st = 0; n.idx = 0; n.fails = 0; n.tmr = 0;
      return n;
    end
    want = (m.idx % 2 == 0) ? (l && !r) : (r && !l);
    case (m.st)
      0: if (r && !l) begin n.st = 1; n.idx = 0; end
      1: begin
        if (c) begin
          n.st = 0; n.idx = 0;
        end else if (want) begin
          if (cnt == digit_of(combo, m.idx)) begin
            if (m.idx == nd - 1) begin n.st = 2; n.idx = 0; n.fails = 0; end
            else n.idx = m.idx + 1;
          end else begin
            n.fail = 1'b1; n.idx = 0; n.st = 0;
`ifdef LOCKOUT_EN
            n.fails = m.fails + 1;
            if (n.fails >= MAXF) begin
              n.fails = MAXF; n.st = 3; n.tmr = LOCK_CYC - 1;
            end
`endif
          end
        end
      end
      2: if (c) n.st = 0;
      3: begin
        if (m.tmr == 0) begin n.st = 0; n.fails = 0; end
        else n.tmr = m.tmr - 1;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_models();
    chk("d3_state",  {29'd0, state3},  m3.st);
    chk("d3_idx",    {30'd0, idx3},    m3.idx);
    chk("d3_locked", {31'd0, locked3}, (m3.st != 2) ? 1 : 0);
    chk("d3_fail",   {31'd0, fail3},   {31'd0, m3.fail});
    chk("d3_lockout",{31'd0, lo3},     (m3.st == 3) ? 1 : 0);
    chk("d4_state",  {29'd0, state4},  m4.st);
    chk("d4_idx",    {30'd0, idx4},    m4.idx);
    chk("d4_locked", {31'd0, locked4}, (m4.st != 2) ? 1 : 0);
    chk("d4_fail",   {31'd0, fail4},   {31'd0, m4.fail});
    chk("d4_lockout",{31'd0, lo4},     (m4.st == 3) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance models at the edge, compare after it.
  task automatic step(input bit s, input bit r, input bit l, input int cnt, input bit c);
    South  = s;
    Right  = r;
    Left   = l;
    Count  = cnt[4:0];
    Center = c;
    @(posedge Clk);
    m3 = model_next(m3, s, r, l, cnt, c, 3, COMBO3);
    m4 = model_next(m4, s, r, l, cnt, c, 4, COMBO4);
    #1;
    check_models();
  endtask

  initial begin
    int lo_cycles;
    int cnt;
    checks = 0;
    errors = 0;
    m3 = '0;
    m4 = '0;
    South = 1'b1; Right = 1'b0; Left = 1'b0; Count = 5'd0; Center = 1'b0;

    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("reset_state",   {29'd0, state3}, 0);
    chk("reset_idx",     {30'd0, idx3},   0);
    chk("reset_locked",  {31'd0, locked3}, 1);
    chk("reset_fail",    {31'd0, fail3},  0);
    chk("reset_lockout", {31'd0, lo3},    0);

    // Correct sequence opens, Center relocks.
    step(1'b0, 1'b1, 1'b0, 0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 13, 1'b0);
    step(1'b0, 1'b1, 1'b0, 7,  1'b0);
    chk("open_not_yet", {31'd0, locked3}, 1);
    step(1'b0, 1'b0, 1'b1, 17, 1'b0);
    chk("open_state",  {29'd0, state3}, 2);
    chk("open_locked", {31'd0, locked3}, 0);
    step(1'b0, 1'b1, 1'b1, 3, 1'b0);
    chk("open_hold",   {29'd0, state3}, 2);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("relock_state",  {29'd0, state3}, 0);
    chk("relock_locked", {31'd0, locked3}, 1);

    // Wrong second digit.
    step(1'b0, 1'b1, 1'b0, 0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 13, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8,  1'b0);
    chk("mismatch_fail", {31'd0, fail3}, 1);
    chk("mismatch_idx",  {30'd0, idx3},  0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("fail_one_cycle", {31'd0, fail3}, 0);

    // Both directions hold at k=1, then Center aborts without Fail.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 13, 1'b0);
    step(1'b0, 1'b1, 1'b1, 7,  1'b0);
    chk("both_hold_state", {29'd0, state3}, 1);
    chk("both_hold_idx",   {30'd0, idx3},   1);
    step(1'b0, 1'b1, 1'b0, 7, 1'b1);
    chk("abort_state", {29'd0, state3}, 0);
    chk("abort_fail",  {31'd0, fail3},  0);

`ifdef LOCKOUT_EN
    // Three mismatches lock both instances out.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int a = 0; a < 3; a++) begin
      step(1'b0, 1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 0, 1'b0);
    end
    chk("lockout_enter", {31'd0, lo3}, 1);
    lo_cycles = 1;
    for (int i = 0; i < 40 && lo3 === 1'b1; i++) begin
      step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           int'($urandom_range(31, 0)), 1'($urandom_range(1, 0)));
      if (lo3 === 1'b1) lo_cycles++;
    end
    chk("lockout_len",   lo_cycles, 16);
    chk("lockout_exit",  {29'd0, state3}, 0);
    step(1'b0, 1'b1, 1'b0, 0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 13, 1'b0);
    step(1'b0, 1'b1, 1'b0, 7,  1'b0);
    step(1'b0, 1'b0, 1'b1, 17, 1'b0);
    chk("after_lockout_open", {29'd0, state3}, 2);
`endif

    // Four-digit instance opens, then reset mid-entry.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 9,  1'b0);
    step(1'b0, 1'b1, 1'b0, 0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 31, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3,  1'b0);
    chk("d4_open", {29'd0, state4}, 2);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 9, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("d4_mid_idx", {30'd0, idx4}, 2);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("d4_reset_state", {29'd0, state4}, 0);
    chk("d4_reset_idx",   {30'd0, idx4},   0);

    // Random traffic, biased toward correct digits so attempts progress.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 0)
        cnt = (m3.st == 1) ? digit_of(COMBO3, m3.idx) : int'($urandom_range(31, 0));
      else if ($urandom_range(1, 0) == 0)
        cnt = (m4.st == 1) ? digit_of(COMBO4, m4.idx) : int'($urandom_range(31, 0));
      else
        cnt = int'($urandom_range(31, 0));
      step(($urandom_range(127, 0) == 0), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), cnt, ($urandom_range(15, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
